// File: rtl/buffer_seq_ctrl_pkg.sv
// Shared types and default geometry for the line-buffer sequencer.
// Widths below are the defaults; instances may override the geometry parameters.
package buf_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, FILL, RUN, BAND_END, DONE} seq_state_t;

  localparam int BUF_HEIGHT_DEF      = 8;
  localparam int BUF_WIDTH_DEF       = 34;
  localparam int MAX_KERNEL_SIZE_DEF = 7;
  localparam int MAX_BANDS_DEF       = 32;

  localparam int IMG_W_W = $clog2(BUF_WIDTH_DEF);
  localparam int KSZ_W   = $clog2(MAX_KERNEL_SIZE_DEF) + 1;
  localparam int BAND_W  = $clog2(MAX_BANDS_DEF) + 1;

endpackage

// File: rtl/buffer_seq_ctrl_if.sv
// Column-in / buffer-drive / patch-out signal bundle of the sequencer.
// slave is the sequencer's view, master is the surrounding datapath's view.
interface buffer_seq_ctrl_if
  import buf_ctrl_pkg::*;
#(
  parameter int DATA_W = BUF_HEIGHT_DEF,
  parameter int X_W    = IMG_W_W,
  parameter int B_W    = BAND_W
);
  logic              col_valid;
  logic              col_ready;
  logic [DATA_W-1:0] col_data;
  logic [DATA_W-1:0] pixel_in;
  logic              shift_enable;
  logic              done;
  logic              patch_valid;
  logic              patch_ready;
  logic [X_W-1:0]    patch_x;
  logic [B_W-1:0]    band_idx;

  modport slave (
    input  col_valid, col_data, patch_ready,
    output col_ready, pixel_in, shift_enable, done, patch_valid, patch_x, band_idx
  );

  modport master (
    output col_valid, col_data, patch_ready,
    input  col_ready, pixel_in, shift_enable, done, patch_valid, patch_x, band_idx
  );
endinterface

// File: rtl/buffer_seq_ctrl_cfg_check.sv
// Combinational validation of the frame configuration presented with start.
// err is high when the geometry cannot be sequenced by this buffer.
module cfg_check
  import buf_ctrl_pkg::*;
#(
  parameter int BUF_HEIGHT      = BUF_HEIGHT_DEF,
  parameter int BUF_WIDTH       = BUF_WIDTH_DEF,
  parameter int MAX_KERNEL_SIZE = MAX_KERNEL_SIZE_DEF,
  parameter int MAX_BANDS       = MAX_BANDS_DEF
) (
  input  logic [$clog2(BUF_WIDTH)-1:0]         img_width,
  input  logic [$clog2(MAX_KERNEL_SIZE):0]     kernel_size,
  input  logic [$clog2(MAX_BANDS):0]           num_bands,
  output logic                                 err
);
  logic [31:0] w32, k32, nb32;

  assign w32  = 32'(img_width);
  assign k32  = 32'(kernel_size);
  assign nb32 = 32'(num_bands);

  assign err = (k32 == 32'd0)
            || (k32 > 32'(MAX_KERNEL_SIZE))
            || (k32 > 32'(BUF_HEIGHT))
            || (w32 < k32)
            || (w32 > 32'(BUF_WIDTH))
            || (nb32 == 32'd0)
            || (nb32 > 32'(MAX_BANDS));
endmodule

// File: rtl/buffer_seq_ctrl.sv
// Line-buffer sequencer: accepts columns, drives the buffer, emits one patch per kernel window.
// Optional stall counter enabled by defining BUF_SEQ_CTRL_PERF_EN.
module buffer_seq_ctrl
  import buf_ctrl_pkg::*;
#(
  parameter int BUF_HEIGHT      = BUF_HEIGHT_DEF,
  parameter int BUF_WIDTH       = BUF_WIDTH_DEF,
  parameter int MAX_KERNEL_SIZE = MAX_KERNEL_SIZE_DEF,
  parameter int MAX_BANDS       = MAX_BANDS_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(BUF_WIDTH)-1:0]     img_width,
  input  logic [$clog2(MAX_KERNEL_SIZE):0] kernel_size,
  input  logic [$clog2(MAX_BANDS):0]       num_bands,
  buffer_seq_ctrl_if.slave                 bus,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             cfg_err,
  output logic [31:0]                      stall_cycles
);
  localparam int XW = $clog2(BUF_WIDTH);
  localparam int KW = $clog2(MAX_KERNEL_SIZE) + 1;
  localparam int BW = $clog2(MAX_BANDS) + 1;

  seq_state_t    state;
  logic [XW-1:0] w_lat;
  logic [XW-1:0] col_cnt;
  logic [KW-1:0] k_lat;
  logic [BW-1:0] nb_lat;
  logic          cfg_bad;
  logic          accept;
  logic          patch_stall;
  logic          fill_last;
  logic          row_last;
  logic          band_last;
  logic          band_free;

  cfg_check #(
    .BUF_HEIGHT      (BUF_HEIGHT),
    .BUF_WIDTH       (BUF_WIDTH),
    .MAX_KERNEL_SIZE (MAX_KERNEL_SIZE),
    .MAX_BANDS       (MAX_BANDS)
  ) u_cfg_check (
    .img_width   (img_width),
    .kernel_size (kernel_size),
    .num_bands   (num_bands),
    .err         (cfg_bad)
  );

  // A held patch blocks new columns so its coordinates cannot be overwritten.
  assign patch_stall      = bus.patch_valid && !bus.patch_ready;
  assign bus.col_ready    = ((state == FILL) || (state == RUN)) && !patch_stall;
  assign accept           = bus.col_valid && bus.col_ready;
  assign bus.shift_enable = accept;
  assign bus.pixel_in     = bus.col_data;
  assign bus.done         = (state == DONE);
  assign frame_done       = (state == DONE);
  assign busy             = (state != IDLE);

  assign fill_last = (col_cnt == XW'(k_lat) - XW'(2));
  assign row_last  = (col_cnt == w_lat - XW'(1));
  assign band_last = (bus.band_idx == nb_lat - BW'(1));
  assign band_free = !bus.patch_valid || bus.patch_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      w_lat           <= '0;
      k_lat           <= '0;
      nb_lat          <= '0;
      col_cnt         <= '0;
      cfg_err         <= 1'b0;
      bus.patch_valid <= 1'b0;
      bus.patch_x     <= '0;
      bus.band_idx    <= '0;
    end else begin
      cfg_err <= 1'b0;
      if (bus.patch_valid && bus.patch_ready) bus.patch_valid <= 1'b0;
      case (state)
        IDLE: begin
          col_cnt      <= '0;
          bus.band_idx <= '0;
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              w_lat  <= img_width;
              k_lat  <= kernel_size;
              nb_lat <= num_bands;
              state  <= (kernel_size == KW'(1)) ? RUN : FILL;
            end
          end
        end
        FILL: begin
          if (accept) begin
            col_cnt <= col_cnt + XW'(1);
            if (fill_last) state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            col_cnt         <= col_cnt + XW'(1);
            bus.patch_valid <= 1'b1;
            bus.patch_x     <= col_cnt - (XW'(k_lat) - XW'(1));
            if (row_last) state <= BAND_END;
          end
        end
        BAND_END: begin
          if (band_free) begin
            if (band_last) begin
              state <= DONE;
            end else begin
              bus.band_idx <= bus.band_idx + BW'(1);
              col_cnt      <= '0;
              state        <= (k_lat == KW'(1)) ? RUN : FILL;
            end
          end
        end
        DONE: begin
          bus.band_idx <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUF_SEQ_CTRL_PERF_EN
  logic in_frame;
  logic stalled;

  assign in_frame = (state == FILL) || (state == RUN) || (state == BAND_END);
  assign stalled  = (bus.col_valid && !bus.col_ready) || patch_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if ((state == IDLE) && start && !cfg_bad) begin
      stall_cycles <= '0;
    end else if (in_frame && stalled && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_buffer_seq_ctrl.sv
// Randomized bench for buffer_seq_ctrl against a patch-list reference model.
// Expected stall count follows BUF_SEQ_CTRL_PERF_EN.
module tb_buffer_seq_ctrl;
  import buf_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [IMG_W_W-1:0] img_width = '0;
  logic [KSZ_W-1:0]   kernel_size = '0;
  logic [BAND_W-1:0]  num_bands = '0;
  logic               busy;
  logic               frame_done;
  logic               cfg_err;
  logic [31:0]        stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  buffer_seq_ctrl_if bus ();

  buffer_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst_n),
    .start        (start),
    .img_width    (img_width),
    .kernel_size  (kernel_size),
    .num_bands    (num_bands),
    .bus          (bus),
    .busy         (busy),
    .frame_done   (frame_done),
    .cfg_err      (cfg_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // Drives one frame and checks the emitted patch stream against the list of
  // every (band, x) window the geometry admits, in raster order.
  task automatic run_frame(input int w, input int k, input int nb, input int vprob,
                           input int rprob, input int stall_n, input bit chk_lat);
    int  exp_b[$];
    int  exp_x[$];
    int  iter = 0, accepted = 0, total, first_iter = -1;
    int  done_cnt = 0, fd_cnt = 0, stall_left, prev_x = 0;
    bit  prev_hold = 0, hold, finished = 0;
    total = w * nb;
    stall_left = stall_n;
    for (int b = 0; b < nb; b++)
      for (int x = 0; x <= w - k; x++) begin
        exp_b.push_back(b);
        exp_x.push_back(x);
      end
    @(negedge clk);
    img_width = IMG_W_W'(w); kernel_size = KSZ_W'(k); num_bands = BAND_W'(nb);
    start = 1'b1; bus.col_valid = 1'b0; bus.patch_ready = 1'b1;
    while (!finished) begin
      @(negedge clk);
      iter++;
      start       = ($urandom_range(99) < 10);
      img_width   = IMG_W_W'($urandom);
      kernel_size = KSZ_W'($urandom);
      num_bands   = BAND_W'($urandom);
      bus.col_valid = (accepted < total) && ($urandom_range(99) < vprob);
      bus.col_data  = 8'($urandom);
      if (stall_left > 0 && bus.patch_valid) begin
        bus.patch_ready = 1'b0; stall_left--; hold = 1;
      end else begin
        bus.patch_ready = ($urandom_range(99) < rprob); hold = 0;
      end
      #1;
      if (iter == 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_frame: got %b want 1", busy); end
      end
      n_cmp++;
      if (bus.shift_enable !== (bus.col_valid && bus.col_ready)) begin
        n_bad++; $display("FAIL shift_enable: got %b want %b", bus.shift_enable, bus.col_valid && bus.col_ready);
      end
      n_cmp++;
      if (bus.pixel_in !== bus.col_data) begin
        n_bad++; $display("FAIL pixel_in: got %h want %h", bus.pixel_in, bus.col_data);
      end
      if (prev_hold) begin
        n_cmp++;
        if (bus.patch_valid !== 1'b1 || int'(bus.patch_x) != prev_x) begin
          n_bad++; $display("FAIL patch_hold: got v=%b x=%0d want v=1 x=%0d", bus.patch_valid, bus.patch_x, prev_x);
        end
      end
      if (hold) begin
        n_cmp++;
        if (bus.col_ready !== 1'b0 || bus.shift_enable !== 1'b0) begin
          n_bad++; $display("FAIL stall_blocks_cols: got rdy=%b shift=%b want 0 0", bus.col_ready, bus.shift_enable);
        end
        if (exp_x.size() > 0) begin
          n_cmp++;
          if (int'(bus.patch_x) != exp_x[0]) begin
            n_bad++; $display("FAIL stall_patch_x: got %0d want %0d", bus.patch_x, exp_x[0]);
          end
        end
      end
      if (bus.patch_valid && first_iter < 0) first_iter = iter;
      if (bus.col_valid && bus.col_ready) accepted++;
      if (bus.patch_valid && bus.patch_ready) begin
        n_cmp++;
        if (exp_b.size() == 0) begin
          n_bad++; $display("FAIL extra_patch: got b=%0d x=%0d want none", bus.band_idx, bus.patch_x);
        end else begin
          if (int'(bus.band_idx) != exp_b[0] || int'(bus.patch_x) != exp_x[0]) begin
            n_bad++; $display("FAIL patch_coord: got b=%0d x=%0d want b=%0d x=%0d",
                              bus.band_idx, bus.patch_x, exp_b[0], exp_x[0]);
          end
          void'(exp_b.pop_front());
          void'(exp_x.pop_front());
        end
      end
      prev_hold = bus.patch_valid && !bus.patch_ready;
      prev_x    = int'(bus.patch_x);
      if (bus.done) done_cnt++;
      if (frame_done) begin fd_cnt++; finished = 1; end
      if (iter > 4000) begin
        n_cmp++; n_bad++; finished = 1;
        $display("FAIL frame_timeout: got no frame_done in %0d cycles want frame_done", iter);
      end
    end
    @(negedge clk);
    start = 1'b0; bus.col_valid = 1'b0; bus.patch_ready = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || bus.done !== 1'b0 || bus.band_idx !== '0) begin
      n_bad++; $display("FAIL post_frame_idle: got busy=%b done=%b band=%0d want 0 0 0", busy, bus.done, bus.band_idx);
    end
    n_cmp++;
    if (exp_b.size() != 0) begin n_bad++; $display("FAIL missing_patches: got %0d left want 0", exp_b.size()); end
    n_cmp++;
    if (accepted != total) begin n_bad++; $display("FAIL columns_accepted: got %0d want %0d", accepted, total); end
    n_cmp++;
    if (done_cnt != 1 || fd_cnt != 1) begin
      n_bad++; $display("FAIL done_pulse: got done=%0d fd=%0d want 1 1", done_cnt, fd_cnt);
    end
    if (chk_lat) begin
      n_cmp++;
      if (first_iter - 1 != k) begin n_bad++; $display("FAIL first_patch_latency: got %0d want %0d", first_iter - 1, k); end
    end
  endtask

  task automatic test_reset();
    bus.col_valid = 1'b1; bus.col_data = 8'h5a; bus.patch_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      #1;
      n_cmp++;
      if ({busy, bus.done, frame_done, cfg_err, bus.patch_valid, bus.col_ready, bus.shift_enable} !== 7'b0) begin
        n_bad++; $display("FAIL reset_flags: got %b want 0000000",
                          {busy, bus.done, frame_done, cfg_err, bus.patch_valid, bus.col_ready, bus.shift_enable});
      end
      n_cmp++;
      if (bus.patch_x !== '0 || bus.band_idx !== '0 || stall_cycles !== 32'd0) begin
        n_bad++; $display("FAIL reset_values: got x=%0d b=%0d st=%0d want 0 0 0", bus.patch_x, bus.band_idx, stall_cycles);
      end
      n_cmp++;
      if (bus.pixel_in !== 8'h5a) begin n_bad++; $display("FAIL reset_pixel_in: got %h want 5a", bus.pixel_in); end
      @(negedge clk);
      rst_n = 1'b1;
    end
    bus.col_valid = 1'b0; bus.patch_ready = 1'b1;
  endtask

  task automatic test_cfg_err();
    int bad_w[7]  = '{2, 8, 8, 40, 35, 8, 8};
    int bad_k[7]  = '{3, 0, 8, 3,  3,  3, 3};
    int bad_nb[7] = '{1, 1, 1, 1,  1,  0, 33};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      img_width = IMG_W_W'(bad_w[i]); kernel_size = KSZ_W'(bad_k[i]); num_bands = BAND_W'(bad_nb[i]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      n_cmp++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
        n_bad++; $display("FAIL cfg_err_pulse[%0d]: got err=%b busy=%b want 1 0", i, cfg_err, busy);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL cfg_err_clear[%0d]: got err=%b busy=%b want 0 0", i, cfg_err, busy);
      end
    end
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    @(negedge clk);
    img_width = IMG_W_W'(8); kernel_size = KSZ_W'(3); num_bands = BAND_W'(2);
    start = 1'b1; bus.patch_ready = 1'b1;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      start = 1'b0; bus.col_valid = 1'b1; bus.col_data = 8'($urandom);
      #1;
      if (bus.patch_valid && bus.patch_x == 2) hit = 1;
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL reach_patch_x2: got none want patch_x=2"); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, bus.done, frame_done, bus.patch_valid, bus.col_ready, bus.shift_enable} !== 6'b0) begin
      n_bad++; $display("FAIL async_reset_flags: got %b want 000000",
                        {busy, bus.done, frame_done, bus.patch_valid, bus.col_ready, bus.shift_enable});
    end
    n_cmp++;
    if (bus.patch_x !== '0 || bus.band_idx !== '0 || stall_cycles !== 32'd0) begin
      n_bad++; $display("FAIL async_reset_values: got x=%0d b=%0d st=%0d want 0 0 0", bus.patch_x, bus.band_idx, stall_cycles);
    end
    @(negedge clk);
    rst_n = 1'b1; bus.col_valid = 1'b0;
    run_frame(8, 3, 1, 100, 100, 0, 1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int k, w, nb;
      k  = $urandom_range(7, 1);
      w  = $urandom_range(34, k);
      nb = $urandom_range(3, 1);
      run_frame(w, k, nb, $urandom_range(100, 50), $urandom_range(100, 40), 0, 0);
    end
    run_frame(34, 7, 2, 100, 100, 0, 1);
    run_frame(7, 7, 2, 70, 60, 0, 0);
  endtask

  task automatic test_stall();
    int want;
`ifdef BUF_SEQ_CTRL_PERF_EN
    want = 5;
`else
    want = 0;
`endif
    run_frame(8, 3, 1, 100, 100, 5, 1);
    n_cmp++;
    if (int'(stall_cycles) != want) begin
      n_bad++; $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, want);
    end
  endtask

  initial begin
    bus.col_valid = 1'b0; bus.col_data = '0; bus.patch_ready = 1'b1;
    test_reset();
    run_frame(8, 3, 1, 100, 100, 0, 1);
    run_frame(8, 3, 1, 100, 100, 4, 1);
    run_frame(4, 1, 3, 100, 100, 0, 1);
    test_cfg_err();
    test_async_reset();
    test_random();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
